// File: rtl/vga_timing_pkg.sv
// Purpose: shared constants and helpers for the VGA raster timing generator.
//   - Default 640x480@60 timing constants.
//   - Region type for one raster axis (active, front porch, sync, back porch).
//   - region_of(): classifies a counter value on one axis.
package vga_timing_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    typedef enum logic [1:0] {
        REG_ACTIVE,
        REG_FP,
        REG_SYNC,
        REG_BP
    } region_e;

    // Each axis is ordered active, front porch, sync, back porch from count 0.
    function automatic region_e region_of(input int cnt, input int act,
                                          input int fp, input int sync);
        if (cnt < act)                  return REG_ACTIVE;
        else if (cnt < act + fp)        return REG_FP;
        else if (cnt < act + fp + sync) return REG_SYNC;
        else                            return REG_BP;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// Purpose: wrapping counter for one raster axis.
// Ports:
//   i_clk   - clock
//   i_rst_n - asynchronous active-low reset, loads RST_VAL
//   i_inc   - advance by one (wraps TOTAL-1 -> 0)
//   o_cnt   - current count
//   o_wrap  - high when this increment wraps the counter (feeds the next axis)
module vga_axis_cnt
    import vga_timing_pkg::*;
#(
    parameter int TOTAL   = 800,
    parameter int RST_VAL = 0,
    localparam int W      = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt,
    output logic         o_wrap
);

    assign o_wrap = i_inc && (o_cnt == W'(TOTAL - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_cnt <= W'(RST_VAL);
        end else if (i_inc) begin
            o_cnt <= o_wrap ? '0 : o_cnt + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: parametrised VGA raster timing generator with pixel-fetch look-ahead.
//   Display counters (h,v) drive sync/blank; look-ahead counters (hl,vl) run
//   REQ_LEAD pixels ahead so an upstream read pipeline returns i_color on time.
// Ports:
//   i_clk, i_rst_n          - clock, asynchronous active-low reset
//   i_en                    - pixel-clock enable
//   i_color                 - {B,G,R} pixel colour, COLOR_W bits per channel
//   o_VGA_R/G/B             - colour, zero while blanked
//   o_H_sync, o_V_sync      - syncs at HS_POL / VS_POL polarity
//   o_blank_n               - high while the displayed pixel is active
//   o_request, o_req_x/y    - fetch strobe and pixel address (0 when idle)
//   o_line_start            - pulse at displayed (0,y) for visible lines
//   o_frame_start           - pulse at displayed (0,0)
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int REQ_LEAD = 2,
    parameter int COLOR_W  = 8,
    localparam int XW      = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1,
    localparam int YW      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_en,
    input  logic [3*COLOR_W-1:0] i_color,
    output logic [COLOR_W-1:0]   o_VGA_R,
    output logic [COLOR_W-1:0]   o_VGA_G,
    output logic [COLOR_W-1:0]   o_VGA_B,
    output logic                 o_H_sync,
    output logic                 o_V_sync,
    output logic                 o_blank_n,
    output logic                 o_request,
    output logic [XW-1:0]        o_req_x,
    output logic [YW-1:0]        o_req_y,
    output logic                 o_line_start,
    output logic                 o_frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = (H_TOT > 1) ? $clog2(H_TOT) : 1;
    localparam int VW    = (V_TOT > 1) ? $clog2(V_TOT) : 1;

    // Display restarts at the top of vertical front porch; look-ahead sits
    // REQ_LEAD pixels further along the frame.
    localparam int LEAD_POS = (V_ACTIVE * H_TOT + REQ_LEAD) % (H_TOT * V_TOT);
    localparam int HL_RST   = LEAD_POS % H_TOT;
    localparam int VL_RST   = LEAD_POS / H_TOT;

    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        REQ_LEAD < 0 || REQ_LEAD > H_FP + H_SYNC + H_BP) begin : g_bad_cfg
        $error("vga_timing_gen: porch/sync must be >= 1 and REQ_LEAD in 0..H_FP+H_SYNC+H_BP");
    end

    logic [HW-1:0] w_h, w_hl, w_h_nxt, w_hl_nxt;
    logic [VW-1:0] w_v, w_vl, w_v_nxt, w_vl_nxt;
    logic          w_h_wrap, w_v_wrap, w_hl_wrap, w_vl_wrap;

    vga_axis_cnt #(.TOTAL(H_TOT), .RST_VAL(0)) u_h (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(i_en), .o_cnt(w_h), .o_wrap(w_h_wrap)
    );
    vga_axis_cnt #(.TOTAL(V_TOT), .RST_VAL(V_ACTIVE)) u_v (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(w_h_wrap), .o_cnt(w_v), .o_wrap(w_v_wrap)
    );
    vga_axis_cnt #(.TOTAL(H_TOT), .RST_VAL(HL_RST)) u_hl (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(i_en), .o_cnt(w_hl), .o_wrap(w_hl_wrap)
    );
    vga_axis_cnt #(.TOTAL(V_TOT), .RST_VAL(VL_RST)) u_vl (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_inc(w_hl_wrap), .o_cnt(w_vl), .o_wrap(w_vl_wrap)
    );

    // Next counter values, so the registered decodes line up with the counters.
    assign w_h_nxt  = !i_en      ? w_h  : (w_h_wrap  ? '0 : w_h  + HW'(1));
    assign w_v_nxt  = !w_h_wrap  ? w_v  : (w_v_wrap  ? '0 : w_v  + VW'(1));
    assign w_hl_nxt = !i_en      ? w_hl : (w_hl_wrap ? '0 : w_hl + HW'(1));
    assign w_vl_nxt = !w_hl_wrap ? w_vl : (w_vl_wrap ? '0 : w_vl + VW'(1));

    region_e w_h_reg, w_v_reg, w_hl_reg, w_vl_reg;
    assign w_h_reg  = region_of(32'(w_h_nxt),  H_ACTIVE, H_FP, H_SYNC);
    assign w_v_reg  = region_of(32'(w_v_nxt),  V_ACTIVE, V_FP, V_SYNC);
    assign w_hl_reg = region_of(32'(w_hl_nxt), H_ACTIVE, H_FP, H_SYNC);
    assign w_vl_reg = region_of(32'(w_vl_nxt), V_ACTIVE, V_FP, V_SYNC);

    logic r_req_flag, r_line_flag, r_frame_flag;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_H_sync     <= ~HS_POL;
            o_V_sync     <= ~VS_POL;
            o_blank_n    <= 1'b0;
            r_req_flag   <= 1'b0;
            r_line_flag  <= 1'b0;
            r_frame_flag <= 1'b0;
        end else begin
            o_H_sync     <= (w_h_reg == REG_SYNC) ? HS_POL : ~HS_POL;
            o_V_sync     <= (w_v_reg == REG_SYNC) ? VS_POL : ~VS_POL;
            o_blank_n    <= (w_h_reg == REG_ACTIVE) && (w_v_reg == REG_ACTIVE);
            r_req_flag   <= (w_hl_reg == REG_ACTIVE) && (w_vl_reg == REG_ACTIVE);
            r_line_flag  <= (w_h_nxt == '0) && (w_v_reg == REG_ACTIVE);
            r_frame_flag <= (w_h_nxt == '0) && (w_v_nxt == '0);
        end
    end

    // Strobes are qualified by the enable so a slow pixel clock sees one pulse.
    assign o_request     = r_req_flag & i_en;
    assign o_line_start  = r_line_flag & i_en;
    assign o_frame_start = r_frame_flag & i_en;
    assign o_req_x       = o_request ? XW'(w_hl) : '0;
    assign o_req_y       = o_request ? YW'(w_vl) : '0;

    assign o_VGA_R = o_blank_n ? i_color[COLOR_W-1:0]           : '0;
    assign o_VGA_G = o_blank_n ? i_color[2*COLOR_W-1:COLOR_W]   : '0;
    assign o_VGA_B = o_blank_n ? i_color[3*COLOR_W-1:2*COLOR_W] : '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: one default-mode instance and two small-mode
// instances (H=8/2/3/1, V=4/1/1/1, positive syncs) with REQ_LEAD 0 and 6.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- default 640x480 instance ----------------
    logic        rst_d_n = 1'b0, en_d = 1'b0;
    logic [23:0] col_d = 24'hFFFFFF;
    logic [7:0]  d_r, d_g, d_b;
    logic        d_hs, d_vs, d_bn, d_req, d_ls, d_fs;
    logic [9:0]  d_rx;
    logic [8:0]  d_ry;

    vga_timing_gen u_dut (
        .i_clk(clk), .i_rst_n(rst_d_n), .i_en(en_d), .i_color(col_d),
        .o_VGA_R(d_r), .o_VGA_G(d_g), .o_VGA_B(d_b),
        .o_H_sync(d_hs), .o_V_sync(d_vs), .o_blank_n(d_bn),
        .o_request(d_req), .o_req_x(d_rx), .o_req_y(d_ry),
        .o_line_start(d_ls), .o_frame_start(d_fs)
    );

    // ---------------- small-mode instances ----------------
    logic        rst_s_n = 1'b0, en_s = 1'b0;
    logic [23:0] col_s = 24'h332211;
    logic [7:0]  a_r, a_g, a_b, b_r, b_g, b_b;
    logic        a_hs, a_vs, a_bn, a_req, a_ls, a_fs;
    logic        b_hs, b_vs, b_bn, b_req, b_ls, b_fs;
    logic [2:0]  a_rx, b_rx;
    logic [1:0]  a_ry, b_ry;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(0), .COLOR_W(8)
    ) u_s0 (
        .i_clk(clk), .i_rst_n(rst_s_n), .i_en(en_s), .i_color(col_s),
        .o_VGA_R(a_r), .o_VGA_G(a_g), .o_VGA_B(a_b),
        .o_H_sync(a_hs), .o_V_sync(a_vs), .o_blank_n(a_bn),
        .o_request(a_req), .o_req_x(a_rx), .o_req_y(a_ry),
        .o_line_start(a_ls), .o_frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(6), .COLOR_W(8)
    ) u_s6 (
        .i_clk(clk), .i_rst_n(rst_s_n), .i_en(en_s), .i_color(col_s),
        .o_VGA_R(b_r), .o_VGA_G(b_g), .o_VGA_B(b_b),
        .o_H_sync(b_hs), .o_V_sync(b_vs), .o_blank_n(b_bn),
        .o_request(b_req), .o_req_x(b_rx), .o_req_y(b_ry),
        .o_line_start(b_ls), .o_frame_start(b_fs)
    );

    // Small-mode reference raster position (displayed pixel).
    int mh = 0, mv = 4;

    task automatic check_small(input string nm, input int lead,
                               input logic hs, input logic vs, input logic bn, input logic req,
                               input logic [2:0] rx, input logic [1:0] ry,
                               input logic ls, input logic fs,
                               input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int lp, lh, lv;
        logic e_bn, e_req;
        lp    = (mv * 14 + mh + lead) % 98;
        lh    = lp % 14;
        lv    = lp / 14;
        e_bn  = (mh < 8) && (mv < 4);
        e_req = en_s && (lh < 8) && (lv < 4);
        check({nm, "_hsync"}, hs, (mh >= 10 && mh < 13));
        check({nm, "_vsync"}, vs, (mv == 5));
        check({nm, "_blank_n"}, bn, e_bn);
        check({nm, "_request"}, req, e_req);
        check({nm, "_req_x"}, rx, e_req ? lh : 0);
        check({nm, "_req_y"}, ry, e_req ? lv : 0);
        check({nm, "_line_start"}, ls, en_s && mh == 0 && mv < 4);
        check({nm, "_frame_start"}, fs, en_s && mh == 0 && mv == 0);
        check({nm, "_R"}, r, e_bn ? 8'h11 : 8'h00);
        check({nm, "_G"}, g, e_bn ? 8'h22 : 8'h00);
        check({nm, "_B"}, b, e_bn ? 8'h33 : 8'h00);
    endtask

    int n_d = 0;
    task automatic go_d(input int target);
        repeat (target - n_d) @(posedge clk);
        n_d = target;
        @(negedge clk);
    endtask

    initial begin
        int cnt_a0, cnt_b0, cnt_a6, cnt_b6, lcnt;
        int lastx, lasty;
        cnt_a0 = 0; cnt_b0 = 0; cnt_a6 = 0; cnt_b6 = 0;

        // ---------------- small mode ----------------
        repeat (3) @(negedge clk);
        check("s0_rst_hsync", a_hs, 0);
        check("s0_rst_vsync", a_vs, 0);
        check("s6_rst_req", b_req, 0);
        check("s6_rst_req_x", b_rx, 0);
        check_small("s0", 0, a_hs, a_vs, a_bn, a_req, a_rx, a_ry, a_ls, a_fs, a_r, a_g, a_b);
        check_small("s6", 6, b_hs, b_vs, b_bn, b_req, b_rx, b_ry, b_ls, b_fs, b_r, b_g, b_b);
        rst_s_n = 1'b1;
        en_s    = 1'b1;
        for (int c = 1; c <= 588; c++) begin
            @(posedge clk);
            if (en_s) begin
                mh++;
                if (mh == 14) begin
                    mh = 0;
                    mv++;
                    if (mv == 7) mv = 0;
                end
            end
            #1;
            en_s = (c + 1 <= 196) ? 1'b1 : ((c + 1) % 2 == 1);
            @(negedge clk);
            check_small("s0", 0, a_hs, a_vs, a_bn, a_req, a_rx, a_ry, a_ls, a_fs, a_r, a_g, a_b);
            check_small("s6", 6, b_hs, b_vs, b_bn, b_req, b_rx, b_ry, b_ls, b_fs, b_r, b_g, b_b);
            if (en_s) check("s0_req_eq_blank", a_req, a_bn);
            if (c <= 196) begin
                cnt_a0 += int'(a_req); cnt_a6 += int'(b_req);
            end else begin
                cnt_b0 += int'(a_req); cnt_b6 += int'(b_req);
            end
            case (c)
                9:   check("s0_hs_h9", a_hs, 0);
                10:  check("s0_hs_h10", a_hs, 1);
                13:  check("s0_hs_h13", a_hs, 0);
                14:  check("s0_vs_v5", a_vs, 1);
                35:  check("s6_req_before", b_req, 0);
                36: begin
                    check("s6_req00", b_req, 1);
                    check("s6_req00_x", b_rx, 0);
                    check("s6_req00_y", b_ry, 0);
                    check("s6_req00_blank", b_bn, 0);
                end
                42: begin
                    check("s0_req00", a_req, 1);
                    check("s0_blank00", a_bn, 1);
                    check("s0_fs00", a_fs, 1);
                end
                85: begin
                    check("s6_last_x", b_rx, 7);
                    check("s6_last_y", b_ry, 3);
                end
                91: begin
                    check("s0_last_x", a_rx, 7);
                    check("s0_last_y", a_ry, 3);
                end
                140: check("s0_fs_next", a_fs, 1);
                default: ;
            endcase
        end
        check("s0_req_count_en", cnt_a0, 64);
        check("s6_req_count_en", cnt_a6, 64);
        check("s0_req_count_alt", cnt_b0, 64);
        check("s6_req_count_alt", cnt_b6, 64);

        // ---------------- default mode, i_en=1 ----------------
        @(negedge clk);
        check("d_rst_hsync", d_hs, 1);
        check("d_rst_vsync", d_vs, 1);
        check("d_rst_blank", d_bn, 0);
        check("d_rst_req", d_req, 0);
        check("d_rst_fs", d_fs, 0);
        check("d_rst_R", d_r, 0);
        rst_d_n = 1'b1;
        en_d    = 1'b1;
        n_d     = 0;
        go_d(100);   check("d_blank_vfp", d_bn, 0);
        go_d(655);   check("d_hs_655", d_hs, 1);
        go_d(656);   check("d_hs_656", d_hs, 0);
        go_d(751);   check("d_hs_751", d_hs, 0);
        go_d(752);   check("d_hs_752", d_hs, 1);
        go_d(1455);  check("d_hs_1455", d_hs, 1);
        go_d(1456);  check("d_hs_1456", d_hs, 0);
        go_d(7999);  check("d_vs_7999", d_vs, 1);
        go_d(8000);  check("d_vs_8000", d_vs, 0);
        go_d(9500);
        check("d_mid_hs", d_hs, 0);
        check("d_mid_vs", d_vs, 0);
        #1 rst_d_n = 1'b0;
        #1;
        check("d_rstnow_hs", d_hs, 1);
        check("d_rstnow_vs", d_vs, 1);
        check("d_rstnow_ls", d_ls, 0);
        @(negedge clk);
        rst_d_n = 1'b1;
        n_d     = 0;

        go_d(35997);
        check("d_req_pre", d_req, 0);
        check("d_fs_pre", d_fs, 0);
        lcnt = 0; lastx = -1; lasty = -1;
        for (int n = 35998; n <= 36797; n++) begin
            if (n > n_d) go_d(n);
            if (d_req) begin
                lcnt++;
                lastx = int'(d_rx);
                lasty = int'(d_ry);
            end
            case (n)
                35998: begin
                    check("d_req00", d_req, 1);
                    check("d_req00_x", d_rx, 0);
                    check("d_req00_y", d_ry, 0);
                    check("d_req00_blank", d_bn, 0);
                end
                35999: begin
                    check("d_blank_m1", d_bn, 0);
                    check("d_req01_x", d_rx, 1);
                end
                36000: begin
                    check("d_blank_rise", d_bn, 1);
                    check("d_fs", d_fs, 1);
                    check("d_ls", d_ls, 1);
                    check("d_R_on", d_r, 8'hFF);
                    check("d_G_on", d_g, 8'hFF);
                    check("d_B_on", d_b, 8'hFF);
                end
                36001: begin
                    check("d_fs_pulse", d_fs, 0);
                    check("d_ls_pulse", d_ls, 0);
                end
                36639: check("d_blank_639", d_bn, 1);
                36640: begin
                    check("d_blank_640", d_bn, 0);
                    check("d_R_off", d_r, 0);
                end
                default: ;
            endcase
        end
        check("d_line_req_count", lcnt, 640);
        check("d_line_last_x", lastx, 639);
        check("d_line_last_y", lasty, 0);
        go_d(36798);
        check("d_req_line1", d_req, 1);
        check("d_req_line1_x", d_rx, 0);
        check("d_req_line1_y", d_ry, 1);
        go_d(37100);
        check("d_active_blank", d_bn, 1);
        check("d_active_G", d_g, 8'hFF);
        #1 rst_d_n = 1'b0;
        #1;
        check("d_rst_act_blank", d_bn, 0);
        check("d_rst_act_G", d_g, 0);
        check("d_rst_act_req", d_req, 0);
        check("d_rst_act_x", d_rx, 0);

        // ---------------- default mode, i_en alternating ----------------
        @(negedge clk);
        rst_d_n = 1'b1;
        en_d    = 1'b1;
        for (int e = 1; e <= 2911; e++) begin
            @(posedge clk);
            #1 en_d = ~en_d;
            @(negedge clk);
            if (!en_d) begin
                if (d_req || d_ls || d_fs) check("d_alt_strobe_idle", {d_req, d_ls, d_fs}, 0);
            end
            case (e)
                1310: check("d_alt_hs_1310", d_hs, 1);
                1311: check("d_alt_hs_1311", d_hs, 0);
                1502: check("d_alt_hs_1502", d_hs, 0);
                1503: check("d_alt_hs_1503", d_hs, 1);
                2910: check("d_alt_hs_2910", d_hs, 1);
                2911: check("d_alt_hs_2911", d_hs, 0);
                default: ;
            endcase
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
